// File: rtl/i2c_eeprom_slave.sv
// I2C EEPROM target: oversampled SCL/SDA, START/STOP detection, 1/2-byte addressing,
// page-wrapped writes and sequential reads from an internal byte array.
`timescale 1ns/1ps
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         ADDR_BYTES = 1,
  parameter int         MEM_DEPTH  = 256,
  parameter int         PAGE_SIZE  = 8,
  localparam int        AW         = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_ADDR_HI, S_ADDR_LO, S_ADDR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
  } state_t;

  localparam logic [AW-1:0] PMASK = AW'(PAGE_SIZE - 1);

  state_t        r_state;
  logic [2:0]    r_scl_sync;
  logic [2:0]    r_sda_sync;
  logic [3:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_addr_hi;
  logic [AW-1:0] r_ptr;
  logic          r_rw;
  logic          r_lo_next;
  logic          r_mack;
  logic [7:0]    r_mem [MEM_DEPTH];

  logic          w_scl_s, w_scl_d, w_sda_s, w_sda_d;
  logic          w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]    w_rx_byte;
  logic [7:0]    w_mem_rd;
  logic          w_mem_we;
  logic [AW-1:0] w_ptr_page_inc;
  logic [AW-1:0] w_addr_ptr;

  // Bits [1] are the synchronised values, bits [2] their previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= 3'b111;
      r_sda_sync <= 3'b111;
    end else begin
      r_scl_sync <= {r_scl_sync[1:0], scl};
      r_sda_sync <= {r_sda_sync[1:0], sda_i};
    end
  end

  assign w_scl_s    = r_scl_sync[1];
  assign w_scl_d    = r_scl_sync[2];
  assign w_sda_s    = r_sda_sync[1];
  assign w_sda_d    = r_sda_sync[2];
  assign w_scl_rise = w_scl_s & ~w_scl_d;
  assign w_scl_fall = ~w_scl_s & w_scl_d;
  // SCL must be stable high across the sample, so a coincident SCL/SDA change is data.
  assign w_start    = w_scl_s & w_scl_d & w_sda_d & ~w_sda_s;
  assign w_stop     = w_scl_s & w_scl_d & ~w_sda_d & w_sda_s;

  assign w_rx_byte      = {r_shift[6:0], w_sda_s};
  assign w_mem_rd       = r_mem[r_ptr];
  assign w_mem_we       = (r_state == S_WDATA) && w_scl_rise && (r_bitcnt == 4'd7);
  assign w_ptr_page_inc = (r_ptr & ~PMASK) | ((r_ptr + 1'b1) & PMASK);
  assign w_addr_ptr     = AW'({r_addr_hi, r_shift});

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_ptr] <= w_rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'd0;
      r_addr_hi <= 8'd0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_lo_next <= 1'b0;
      r_mack    <= 1'b1;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (w_stop) begin
        r_state  <= S_IDLE;
        r_bitcnt <= 4'd0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
      end else if (w_start) begin
        r_state  <= S_DEV;
        r_bitcnt <= 4'd0;
        sda_oe   <= 1'b0;
      end else begin
        case (r_state)
          S_DEV, S_ADDR_HI, S_ADDR_LO, S_WDATA: begin
            if (w_scl_rise && r_bitcnt < 4'd8) begin
              r_shift  <= w_rx_byte;
              r_bitcnt <= r_bitcnt + 4'd1;
            end
            if (w_mem_we) begin
              wr_strobe <= 1'b1;
              wr_addr   <= r_ptr;
              wr_data   <= w_rx_byte;
              r_ptr     <= w_ptr_page_inc;
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              r_bitcnt <= 4'd0;
              case (r_state)
                S_DEV: begin
                  if (r_shift[7:1] != DEV_ADDR) begin
                    r_state <= S_WAIT;
                    busy    <= 1'b0;
                  end else begin
                    r_state <= S_DEV_ACK;
                    r_rw    <= r_shift[0];
                    sda_oe  <= 1'b1;
                    busy    <= 1'b1;
                  end
                end
                S_ADDR_HI: begin
                  r_addr_hi <= r_shift;
                  r_lo_next <= 1'b1;
                  r_state   <= S_ADDR_ACK;
                  sda_oe    <= 1'b1;
                end
                S_ADDR_LO: begin
                  r_ptr     <= w_addr_ptr;
                  r_lo_next <= 1'b0;
                  r_state   <= S_ADDR_ACK;
                  sda_oe    <= 1'b1;
                end
                default: begin
                  r_state <= S_WDATA_ACK;
                  sda_oe  <= 1'b1;
                end
              endcase
            end
          end
          S_DEV_ACK: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                r_state <= S_RDATA;
                r_shift <= w_mem_rd;
                sda_oe  <= ~w_mem_rd[7];
              end else begin
                r_state <= (ADDR_BYTES == 2) ? S_ADDR_HI : S_ADDR_LO;
                sda_oe  <= 1'b0;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_state <= r_lo_next ? S_ADDR_LO : S_WDATA;
              sda_oe  <= 1'b0;
            end
          end
          S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_state <= S_WDATA;
              sda_oe  <= 1'b0;
            end
          end
          S_RDATA: begin
            if (w_scl_rise && r_bitcnt < 4'd8) r_bitcnt <= r_bitcnt + 4'd1;
            if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_state  <= S_RDATA_ACK;
                r_bitcnt <= 4'd0;
                sda_oe   <= 1'b0;
              end else begin
                r_shift <= {r_shift[6:0], 1'b0};
                sda_oe  <= ~r_shift[6];
              end
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              r_mack <= w_sda_s;
              if (!w_sda_s) r_ptr <= r_ptr + 1'b1;
            end
            if (w_scl_fall) begin
              if (!r_mack) begin
                r_state <= S_RDATA;
                r_shift <= w_mem_rd;
                sda_oe  <= ~w_mem_rd[7];
              end else begin
                r_state <= S_WAIT;
              end
            end
          end
          S_IDLE, S_WAIT: sda_oe <= 1'b0;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
